// File: rtl/sprite_palette_pkg.sv
// Shared types and defaults for the sprite palette bank.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sprite_palette_pkg;

    // Width of the brightness shift amount (0..3).
    localparam int DIM_W = 2;

    // Default geometry used when a parent does not override it.
    localparam int PAL_INDEX_W      = 4;
    localparam int PAL_NUM_PALETTES = 4;
    localparam int PAL_COLOR_W      = 4;

    typedef struct packed {
        logic [PAL_COLOR_W-1:0] r;
        logic [PAL_COLOR_W-1:0] g;
        logic [PAL_COLOR_W-1:0] b;
    } rgb_t;

    typedef enum logic {
        PAL_INIT  = 1'b0,
        PAL_READY = 1'b1
    } pal_state_t;

    // Bank-select width; a single bank still gets one (always zero) bit.
    function automatic int sel_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Lookup, colour-out and CPU write bundle of the sprite palette bank.
// Latency: n/a (wires only); colour returns 2 cycles after rd_valid.
// Backpressure: none on lookups; writes are gated only by wr_ready.
// Ports: rd_* lookup request, dim shift, out_valid/red/green/blue/transparent
// result, wr_* CPU write with wr_ready, init_done clear-sweep status.
interface sprite_palette_bank_if
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W = PAL_INDEX_W,
    parameter int SEL_W   = 2,
    parameter int COLOR_W = PAL_COLOR_W
);
    logic                 rd_valid;
    logic [SEL_W-1:0]     rd_sel;
    logic [INDEX_W-1:0]   rd_index;
    logic [DIM_W-1:0]     dim;

    logic                 out_valid;
    logic [COLOR_W-1:0]   red;
    logic [COLOR_W-1:0]   green;
    logic [COLOR_W-1:0]   blue;
    logic                 transparent;

    logic                 wr_en;
    logic                 wr_ready;
    logic [SEL_W-1:0]     wr_sel;
    logic [INDEX_W-1:0]   wr_index;
    logic [3*COLOR_W-1:0] wr_rgb;

    logic                 init_done;

    // Sprite fetch / CPU side.
    modport master (
        output rd_valid, rd_sel, rd_index, dim,
        output wr_en, wr_sel, wr_index, wr_rgb,
        input  out_valid, red, green, blue, transparent,
        input  wr_ready, init_done
    );

    // Palette bank side.
    modport slave (
        input  rd_valid, rd_sel, rd_index, dim,
        input  wr_en, wr_sel, wr_index, wr_rgb,
        output out_valid, red, green, blue, transparent,
        output wr_ready, init_done
    );

endinterface

// File: rtl/palette_ram_1w1r.sv
// Simple dual-port synchronous RAM, one write and one read port, read-before-write.
// Latency: 1 cycle read; a same-address write is visible to reads one cycle later.
// Backpressure: none; both ports accept every cycle.
// Ports: clk; we/waddr/wdata write port; raddr/rdata registered read port.
module palette_ram_1w1r #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 12
) (
    input  logic                                    clk,
    input  logic                                    we,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr,
    input  logic [WIDTH-1:0]                        wdata,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr,
    output logic [WIDTH-1:0]                        rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so it maps onto block RAM;
    // contents are cleared by the owner's init sweep instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sprite_palette_bank.sv
// Runtime-writable multi-bank palette: {sel,index} -> dimmed RGB plus transparency key.
// Latency: 2 cycles rd_valid -> out_valid, fully streaming, one lookup per cycle.
// Backpressure: none on lookups; writes dropped until the reset clear sweep ends (wr_ready).
// Ports: clk, rst_n (async active-low), bus (slave modport of sprite_palette_bank_if).
module sprite_palette_bank
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W         = PAL_INDEX_W,
    parameter int NUM_PALETTES    = PAL_NUM_PALETTES,
    parameter int COLOR_W         = PAL_COLOR_W,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sprite_palette_bank_if.slave bus
);

    localparam int SEL_W  = sel_width(NUM_PALETTES);
    localparam int ADDR_W = SEL_W + INDEX_W;
    localparam int DEPTH  = NUM_PALETTES << INDEX_W;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = 3 * COLOR_W;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pix_t;

    // ---------------------------------------------------------------
    // Init sweep FSM: clear every entry once after reset, then READY.
    // ---------------------------------------------------------------
    pal_state_t          state;
    logic [ADDR_W-1:0]   init_cnt;
    logic                ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PAL_INIT;
            init_cnt <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                PAL_INIT: begin
                    if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                        state   <= PAL_READY;
                        ready_q <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= PAL_READY;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Bank-select range checks; only a non-power-of-2 bank count can
    // present a select with no backing storage.
    // ---------------------------------------------------------------
    logic rd_in_range;
    logic wr_in_range;

    generate
        if (NUM_PALETTES == (1 << SEL_W)) begin : g_full_sel
            assign rd_in_range = 1'b1;
            assign wr_in_range = 1'b1;
        end else begin : g_part_sel
            assign rd_in_range = (32'(bus.rd_sel) < 32'(NUM_PALETTES));
            assign wr_in_range = (32'(bus.wr_sel) < 32'(NUM_PALETTES));
        end
    endgenerate

    // ---------------------------------------------------------------
    // Write port mux: the sweep owns the port while in INIT.
    // ---------------------------------------------------------------
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [ADDR_W-1:0] ram_raddr;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == PAL_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_cnt;
        end else begin
            ram_we    = bus.wr_en && ready_q && wr_in_range;
            ram_waddr = {bus.wr_sel, bus.wr_index};
            ram_wdata = bus.wr_rgb;
        end
    end

    // Out-of-range reads are steered to entry 0 and zeroed in stage 2.
    assign ram_raddr = rd_in_range ? {bus.rd_sel, bus.rd_index} : '0;

    palette_ram_1w1r #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (RAM_AW'(ram_waddr)),
        .wdata (ram_wdata),
        .raddr (RAM_AW'(ram_raddr)),
        .rdata (ram_rdata)
    );

    // ---------------------------------------------------------------
    // Stage 1: sideband registered alongside the RAM read.
    // s1_zero forces black for reads of not-yet-cleared entries during
    // the sweep and for selects with no backing bank.
    // ---------------------------------------------------------------
    logic               s1_valid;
    logic [INDEX_W-1:0] s1_index;
    logic [DIM_W-1:0]   s1_dim;
    logic               s1_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_dim   <= '0;
            s1_zero  <= 1'b0;
        end else begin
            s1_valid <= bus.rd_valid;
            s1_index <= bus.rd_index;
            s1_dim   <= bus.dim;
            s1_zero  <= (state == PAL_INIT) || !rd_in_range;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: dim, transparency key, registered outputs. Colour and
    // key hold their last value while no lookup is in flight.
    // ---------------------------------------------------------------
    pix_t               rd_pix;
    logic               out_valid_q;
    logic [COLOR_W-1:0] red_q;
    logic [COLOR_W-1:0] green_q;
    logic [COLOR_W-1:0] blue_q;
    logic               transparent_q;

    assign rd_pix = ram_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            transparent_q <= 1'b0;
        end else begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                red_q         <= s1_zero ? '0 : (rd_pix.r >> s1_dim);
                green_q       <= s1_zero ? '0 : (rd_pix.g >> s1_dim);
                blue_q        <= s1_zero ? '0 : (rd_pix.b >> s1_dim);
                transparent_q <= (s1_index == INDEX_W'(TRANSPARENT_IDX));
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.red         = red_q;
    assign bus.green       = green_q;
    assign bus.blue        = blue_q;
    assign bus.transparent = transparent_q;
    assign bus.wr_ready    = ready_q;
    assign bus.init_done   = ready_q;

endmodule

// File: tb/tb_sprite_palette_bank.sv
// Self-checking bench for sprite_palette_bank (default 4 banks x 16 entries x 4-bit RGB).
// Latency: expects colour 2 cycles after each lookup, init_done 64 cycles after reset release.
// Backpressure: writes issued before init_done are expected to be dropped.
module tb_sprite_palette_bank;
    import sprite_palette_pkg::*;

    localparam int SWEEP = 64;

    typedef struct {
        logic       v;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       t;
    } exp_t;

    logic clk;
    logic rst_n;

    sprite_palette_bank_if #(.INDEX_W(4), .SEL_W(2), .COLOR_W(4)) bus ();

    sprite_palette_bank #(
        .INDEX_W         (4),
        .NUM_PALETTES    (4),
        .COLOR_W         (4),
        .TRANSPARENT_IDX (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    int          edges_done;
    exp_t        exp_q[$];
    logic [11:0] model [64];
    rgb_t        last_rgb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock of stimulus: drive, push expectation, clock, compare.
    task automatic step(input logic v, input logic [1:0] sel, input logic [3:0] idx,
                        input logic [1:0] dm, input logic we, input logic [1:0] ws,
                        input logic [3:0] wi, input logic [11:0] wd);
        exp_t        e;
        exp_t        got;
        logic [11:0] word;
        bus.rd_valid = v;
        bus.rd_sel   = sel;
        bus.rd_index = idx;
        bus.dim      = dm;
        bus.wr_en    = we;
        bus.wr_sel   = ws;
        bus.wr_index = wi;
        bus.wr_rgb   = wd;
        if (v) begin
            word       = model[{sel, idx}];
            e.v        = 1'b1;
            e.r        = word[11:8] >> dm;
            e.g        = word[7:4] >> dm;
            e.b        = word[3:0] >> dm;
            e.t        = (idx == 4'd0);
            last_rgb.r = e.r;
            last_rgb.g = e.g;
            last_rgb.b = e.b;
        end else begin
            e.v = 1'b0;
            e.r = last_rgb.r;
            e.g = last_rgb.g;
            e.b = last_rgb.b;
            e.t = 1'b0;
        end
        exp_q.push_back(e);
        // Read-before-write: the lookup above already used the old word.
        if (we && edges_done >= SWEEP) model[{ws, wi}] = wd;
        @(posedge clk);
        #1;
        edges_done++;
        if (exp_q.size() == 2) begin
            got = exp_q.pop_front();
            n_checks++;
            if (bus.out_valid !== got.v) begin
                n_fail++;
                $display("FAIL out_valid @%0t: got %b expected %b", $time, bus.out_valid, got.v);
            end
            n_checks++;
            if ({bus.red, bus.green, bus.blue} !== {got.r, got.g, got.b}) begin
                n_fail++;
                $display("FAIL colour @%0t: got %h expected %h", $time,
                         {bus.red, bus.green, bus.blue}, {got.r, got.g, got.b});
            end
            if (got.v) begin
                n_checks++;
                if (bus.transparent !== got.t) begin
                    n_fail++;
                    $display("FAIL transparent @%0t: got %b expected %b", $time, bus.transparent, got.t);
                end
            end
        end
        n_checks++;
        if (bus.init_done !== (edges_done >= SWEEP) || bus.wr_ready !== (edges_done >= SWEEP)) begin
            n_fail++;
            $display("FAIL ready_flags @%0t: got init_done=%b wr_ready=%b expected %b", $time,
                     bus.init_done, bus.wr_ready, (edges_done >= SWEEP));
        end
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 4'd0, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
    endtask

    // Assert reset now, check outputs cleared immediately, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.red, bus.green, bus.blue, bus.transparent, bus.wr_ready, bus.init_done} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs @%0t: got %h expected 0", $time,
                     {bus.out_valid, bus.red, bus.green, bus.blue, bus.transparent, bus.wr_ready, bus.init_done});
        end
        exp_q.delete();
        for (int i = 0; i < 64; i++) model[i] = 12'h000;
        last_rgb   = '0;
        edges_done = 0;
        bus.rd_valid = 1'b0;
        bus.wr_en    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Count cycles until init_done, with a user write pending the whole time.
    task automatic poll_sweep(input string name);
        int   count;
        logic done;
        count = 0;
        done  = 1'b0;
        while (!done && count < 200) begin
            step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd1, 4'd3, 12'hFFF);
            count++;
            if (bus.init_done === 1'b1) done = 1'b1;
        end
        n_checks++;
        if (count != SWEEP) begin
            n_fail++;
            $display("FAIL %s: init_done after %0d cycles, expected %0d", name, count, SWEEP);
        end
    endtask

    task automatic test_reset();
        do_reset();
        poll_sweep("sweep_len");
        idle();
    endtask

    task automatic test_write_read();
        step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd2, 4'd5, 12'hB34);
        step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd0, 4'd0, 12'hABC);
        step(1'b1, 2'd2, 4'd5, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd2, 4'd5, 2'd2, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd0, 4'd0, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd3, 4'd0, 2'd1, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd1, 4'd3, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd2, 4'd5, 2'd3, 1'b0, 2'd0, 4'd0, 12'h000);
        idle();
        idle();
    endtask

    task automatic test_collision();
        step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd0, 4'd7, 12'h123);
        step(1'b1, 2'd0, 4'd7, 2'd0, 1'b1, 2'd0, 4'd7, 12'h456);
        step(1'b1, 2'd0, 4'd7, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        idle();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] k;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            step(1'b0, 2'd0, 4'd0, 2'd0, 1'b1, 2'd3, k, {k, ~k, k ^ 4'h5});
        end
        for (int i = 0; i < 32; i++) begin
            k = 4'(i >> 1);
            step(((i % 2) == 0), 2'd3, k, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        end
        for (int i = 0; i < 16; i++) begin
            k = 4'(15 - i);
            step(1'b1, 2'd3, k, 2'($urandom_range(0, 3)), 1'b0, 2'd0, 4'd0, 12'h000);
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'd2, 4'd5, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd3, 4'd9, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 2'($urandom_range(0, 3)), 4'(i % 4), 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        end
        do_reset();
        poll_sweep("sweep_len_after_restart");
        step(1'b1, 2'd2, 4'd5, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd3, 4'd9, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd0, 4'd7, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        step(1'b1, 2'd1, 4'd3, 2'd0, 1'b0, 2'd0, 4'd0, 12'h000);
        idle();
        idle();
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        edges_done   = 0;
        last_rgb     = '0;
        rst_n        = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_sel   = '0;
        bus.rd_index = '0;
        bus.dim      = '0;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = '0;
        bus.wr_index = '0;
        bus.wr_rgb   = '0;
        #12;
        test_reset();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Runtime-writable, multi-bank colour palette for sprite rendering.
- Maps a sprite pixel index and a palette select to per-channel colour through a 2-stage registered pipeline.
- Adds transparency keying and brightness dimming.
- Sits between sprite ROM readout and the VGA colour mux. Palettes are loaded by the CPU-side write port instead of being fixed at synthesis.

Parameters:
- INDEX_W, 4, bits of pixel index; entries per bank = 2**INDEX_W.
- NUM_PALETTES, 4, number of banks (>=1).
- COLOR_W, 4, bits per colour channel.
- TRANSPARENT_IDX, 0, index value reported as transparent.
- Derived: SEL_W = max(1, clog2(NUM_PALETTES)).

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- rd_valid  in  1  lookup request this cycle.
- rd_sel  in  SEL_W  palette bank for lookup.
- rd_index  in  INDEX_W  pixel index for lookup.
- out_valid  out  1  output colour valid.
- red  out  COLOR_W  red channel.
- green  out  COLOR_W  green channel.
- blue  out  COLOR_W  blue channel.
- transparent  out  1  pixel is transparent key.
- dim  in  2  brightness shift, 0..3, applied right-shift per channel.
- wr_en  in  1  write request.
- wr_ready  out  1  writes accepted.
- wr_sel  in  SEL_W  bank to write.
- wr_index  in  INDEX_W  entry to write.
- wr_rgb  in  3*COLOR_W  {R,G,B} data.
- init_done  out  1  clear sweep finished.

Behaviour:
- Reset (async assert, sync release) puts outputs at: out_valid=0, red/green/blue=0, transparent=0, wr_ready=0, init_done=0. The init counter is reset to 0.
- Init sweep:
  - After Reset_n deasserts, a counter walks every entry, writing 0 one entry per cycle.
  - The sweep takes NUM_PALETTES*2**INDEX_W cycles.
  - On the cycle after the last entry is written, init_done=1 and wr_ready=1. Both stay 1 until reset.
- During the sweep:
  - wr_en is ignored.
  - Lookups still flow through the pipeline and return colour 0 with the correct transparent flag.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from entry 0 after release. Pipeline contents are discarded.
- State machine: INIT (counter running) -> READY (terminal). Only Reset_n returns it to INIT.
- Write: when wr_en && wr_ready, entry {wr_sel, wr_index} takes wr_rgb at the clock edge. There is no back-pressure beyond wr_ready.
- Lookup pipeline, latency 2:
  - Stage 1: synchronous RAM read at {rd_sel, rd_index}. rd_valid, rd_index and dim are registered alongside.
  - Stage 2: each channel = stored >> dim (logical, width preserved). transparent = (index == TRANSPARENT_IDX). All outputs are registered.
  - out_valid at cycle N+2 equals rd_valid at cycle N.
  - When out_valid=0, colour outputs hold their last value.
- Read/write collision (same entry, same cycle): the read returns the old data (read-before-write). A read one cycle later returns the new data.
- Out-of-range rd_sel (>= NUM_PALETTES, non-power-of-2 counts): colour 0, transparent computed normally, out_valid passes through. The same out-of-range condition on wr_sel makes the write a no-op.
- The pipeline is fully streaming: one lookup per cycle, no bubbles.
- Storage: NUM_PALETTES*2**INDEX_W words of 3*COLOR_W bits, inferred as block RAM with one write port and one read port.

Decomposition:
- Package sprite_palette_pkg holds:
  - typedef rgb_t (struct of three COLOR_W channels), parametrised via localparam defaults.
  - DIM_W = 2.
  - The init-sweep state enum {PAL_INIT, PAL_READY}.
- One sub-module: palette_ram_1w1r. It is a simple dual-port synchronous RAM, read-before-write, parameters DEPTH and WIDTH.
- The init counter, write muxing (sweep vs. user) and the output pipeline live in the top module.

Test Plan (defaults: INDEX_W=4, NUM_PALETTES=4, COLOR_W=4; 64-cycle sweep):
- Reset release, then poll: init_done and wr_ready rise exactly 64 cycles after Reset_n goes high. wr_en=1 during the sweep (sel 1, idx 3, 12'hFFF) leaves that entry 0 when read after init.
- Write sel 2, idx 5 = 12'hB34, then rd_valid sel 2 idx 5 dim 0 -> 2 cycles later out_valid=1, red=B, green=3, blue=4, transparent=0.
- Same entry with dim=2 -> red=2, green=0, blue=1. rd_index=0 on any bank -> transparent=1.
- Write and read the same entry in the same cycle (old 12'h123, new 12'h456) -> first result 123. A read issued the next cycle returns 456.
- Back-to-back lookups over all 16 indices of bank 3 with rd_valid toggling 1,0,1... -> out_valid repeats the pattern delayed 2 cycles. Colours match the written table, and colour holds when out_valid=0.
- Assert Reset_n low mid-stream and mid-sweep (cycle 30) -> outputs 0 immediately. After release the sweep restarts: init_done at 64 cycles. Previously written entries read 0.
